// File: rtl/ram_seq_buf.sv
// ram_seq_buf: single-port word buffer with direct and auto-increment access plus a sequential clear.
module ram_seq_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] ptr,
  output logic              busy
);
  localparam logic [2:0] OP_WRITE = 3'd0;
  localparam logic [2:0] OP_READ = 3'd1;
  localparam logic [2:0] OP_SETPTR = 3'd2;
  localparam logic [2:0] OP_WRITE_INC = 3'd3;
  localparam logic [2:0] OP_READ_INC = 3'd4;
  localparam logic [2:0] OP_CLEAR = 3'd5;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] ptr_q, ptr_d, clr_q, clr_d, wa, ra;
  logic [DATA_W-1:0] rd_data_q, rd_data_d, wd;
  logic rd_valid_q, rd_valid_d, acc, we, rd, inc;
  assign cmd_ready = en && state_q == IDLE;
  assign acc = cmd_valid && cmd_ready;
  assign busy = state_q == CLEAR;
  assign rd_valid = rd_valid_q && en;
  assign rd_data = rd_data_q;
  assign ptr = ptr_q;
  always_comb begin
    rd = acc && (cmd_op == OP_READ || cmd_op == OP_READ_INC);
    inc = acc && (cmd_op == OP_WRITE_INC || cmd_op == OP_READ_INC);
    we = en && (busy || acc && (cmd_op == OP_WRITE || cmd_op == OP_WRITE_INC));
    wa = busy ? clr_q : cmd_op == OP_WRITE ? cmd_addr : ptr_q;
    wd = busy ? '0 : cmd_wdata;
    ra = cmd_op == OP_READ ? cmd_addr : ptr_q;
    ptr_d = acc && cmd_op == OP_SETPTR ? cmd_addr : inc ? ptr_q + 1'b1 : ptr_q;
    // the clear counter wraps to 0 on its own after the last address
    clr_d = en && busy ? clr_q + 1'b1 : clr_q;
    state_d = acc && cmd_op == OP_CLEAR ? CLEAR :
              en && busy && clr_q == ADDR_W'(DEPTH - 1) ? IDLE : state_q;
    rd_valid_d = rd;
    rd_data_d = rd ? mem_q[ra] : rd_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      clr_q <= '0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      clr_q <= clr_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && we) mem_q[wa] <= wd;
  end
endmodule
